// File: rtl/neuron_seq_driver.sv
// Sequencer that buffers W/X vectors, streams them into one neuron_Nbits and returns its ReLU result.
// Optional zero-skip gating of the MAC enable is built when NEURON_SEQ_ZSKIP_EN is defined.
module neuron_seq_driver #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic signed [WIDTH-1:0]  ld_w,
  input  logic signed [WIDTH-1:0]  ld_x,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  output logic                     busy,
  output logic                     n_rst,
  output logic                     n_en,
  output logic signed [WIDTH-1:0]  n_W,
  output logic signed [WIDTH-1:0]  n_X,
  input  logic signed [WIDTH-1:0]  n_out,
`ifdef NEURON_SEQ_ZSKIP_EN
  output logic [ADDR_W:0]          skip_cnt,
`endif
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [WIDTH-1:0]  res_data
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t                   state;
  logic [ADDR_W-1:0]        idx;
  logic [ADDR_W:0]          len_q;
  logic signed [WIDTH-1:0]  wbuf [DEPTH];
  logic signed [WIDTH-1:0]  xbuf [DEPTH];

  logic [ADDR_W-1:0]        idx_nxt;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [WIDTH-1:0]  rd_w;
  logic signed [WIDTH-1:0]  rd_x;
  logic                     rd_live;
  logic                     last_pair;

  // The MAC clear is the only combinational output so the neuron is cleared in the same cycle as rst.
  assign n_rst = rst | (state == CLEAR);

  // Outputs are registered on the transition, so the pair fetched here is the one presented next cycle.
  assign idx_nxt   = idx + 1'b1;
  assign rd_addr   = (state == STREAM) ? idx_nxt : '0;
  assign rd_w      = wbuf[rd_addr];
  assign rd_x      = xbuf[rd_addr];
  assign last_pair = ({1'b0, idx} == (len_q - 1'b1));

`ifdef NEURON_SEQ_ZSKIP_EN
  assign rd_live = (rd_w != '0) && (rd_x != '0);
`else
  assign rd_live = 1'b1;
`endif

  // Buffers carry data only and survive rst.
  always_ff @(posedge clk) begin
    if (ld_en && (state == IDLE)) begin
      wbuf[ld_addr] <= ld_w;
      xbuf[ld_addr] <= ld_x;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      n_en      <= 1'b0;
      n_W       <= '0;
      n_X       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      idx       <= '0;
      len_q     <= '0;
`ifdef NEURON_SEQ_ZSKIP_EN
      skip_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= (len > DEPTH_L) ? DEPTH_L : len;
            busy  <= 1'b1;
            state <= CLEAR;
          end
        end
        CLEAR: begin
          idx <= '0;
`ifdef NEURON_SEQ_ZSKIP_EN
          skip_cnt <= '0;
`endif
          if (len_q != '0) begin
            n_en  <= rd_live;
            n_W   <= rd_w;
            n_X   <= rd_x;
`ifdef NEURON_SEQ_ZSKIP_EN
            skip_cnt <= {{ADDR_W{1'b0}}, ~rd_live};
`endif
            state <= STREAM;
          end else begin
            n_en  <= 1'b0;
            state <= DRAIN;
          end
        end
        STREAM: begin
          if (last_pair) begin
            n_en  <= 1'b0;
            state <= DRAIN;
          end else begin
            idx  <= idx_nxt;
            n_en <= rd_live;
            n_W  <= rd_w;
            n_X  <= rd_x;
`ifdef NEURON_SEQ_ZSKIP_EN
            skip_cnt <= skip_cnt + {{ADDR_W{1'b0}}, ~rd_live};
`endif
          end
        end
        DRAIN: begin
          res_data <= n_out;
          busy     <= 1'b0;
          state    <= DONE;
        end
        DONE: begin
          // First DONE cycle raises valid; the handshake is only honoured once valid is visible.
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_seq_driver.sv
// Self-checking bench for neuron_seq_driver with a behavioural neuron and a vector-level reference model.
// Build with NEURON_SEQ_ZSKIP_EN defined to exercise the zero-skip variant.
module tb_neuron_seq_driver;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     ld_en;
  logic [ADDR_W-1:0]        ld_addr;
  logic signed [WIDTH-1:0]  ld_w;
  logic signed [WIDTH-1:0]  ld_x;
  logic                     start;
  logic [ADDR_W:0]          len;
  logic                     busy;
  logic                     n_rst;
  logic                     n_en;
  logic signed [WIDTH-1:0]  n_W;
  logic signed [WIDTH-1:0]  n_X;
  logic signed [WIDTH-1:0]  n_out;
  logic                     res_valid;
  logic                     res_ready;
  logic signed [WIDTH-1:0]  res_data;
`ifdef NEURON_SEQ_ZSKIP_EN
  logic [ADDR_W:0]          skip_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int wm [DEPTH];
  int xm [DEPTH];
  int acc;

  always #5 clk = ~clk;

  neuron_seq_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_w(ld_w), .ld_x(ld_x),
    .start(start), .len(len), .busy(busy), .n_rst(n_rst), .n_en(n_en), .n_W(n_W), .n_X(n_X),
    .n_out(n_out),
`ifdef NEURON_SEQ_ZSKIP_EN
    .skip_cnt(skip_cnt),
`endif
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  function automatic int relu_sat(input int v);
    if (v < 0) return 0;
    if (v > (2**(WIDTH-1) - 1)) return 2**(WIDTH-1) - 1;
    return v;
  endfunction

  // Behavioural neuron: clearable MAC with a saturating ReLU output.
  always_ff @(posedge clk) begin
    if (n_rst) acc <= 0;
    else if (n_en) acc <= acc + int'(n_W) * int'(n_X);
  end
  assign n_out = WIDTH'(relu_sat(acc));

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic load(input int a, input int w, input int x);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_w = WIDTH'(w); ld_x = WIDTH'(x);
    @(negedge clk);
    ld_en = 1'b0;
    wm[a] = w;
    xm[a] = x;
  endtask

  task automatic run(input string tag, input int l, input int hold);
    int n, expv, exp_pat, pat, k, nz;
    n = (l > DEPTH) ? DEPTH : l;
    expv = 0; exp_pat = 0; nz = 0;
    for (int i = 0; i < n; i++) begin
      expv += wm[i] * xm[i];
      if (wm[i] != 0 && xm[i] != 0) nz++;
`ifdef NEURON_SEQ_ZSKIP_EN
      if (wm[i] != 0 && xm[i] != 0) exp_pat |= (1 << i);
`else
      exp_pat |= (1 << i);
`endif
    end
    expv = relu_sat(expv);

    @(negedge clk);
    start = 1'b1; len = (ADDR_W+1)'(l);
    @(negedge clk);
    start = 1'b0;
    k = 0; pat = 0;
    check_eq({tag, "_clr"}, int'(n_rst), 1);
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
      if (n_en && k <= 31) pat |= (1 << (k - 1));
    end
    check_eq({tag, "_lat"}, k, n + 3);
    check_eq({tag, "_en"}, pat, exp_pat);
    check_eq({tag, "_data"}, int'(res_data), expv);
`ifdef NEURON_SEQ_ZSKIP_EN
    check_eq({tag, "_skip"}, int'(skip_cnt), n - nz);
`endif

    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      if (h == 1) begin start = 1'b1; len = 5'd2; end
      if (h == 2) begin ld_en = 1'b1; ld_addr = '0; ld_w = 8'sd99; ld_x = 8'sd99; end
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
      check_eq({tag, "_hold_v"}, int'(res_valid), 1);
      check_eq({tag, "_hold_d"}, int'(res_data), expv);
    end

    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check_eq({tag, "_ack_v"}, int'(res_valid), 0);
    @(negedge clk);
    check_eq({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_w = '0; ld_x = '0;
    start = 1'b0; len = '0; res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin wm[i] = 0; xm[i] = 0; end
    repeat (2) @(negedge clk);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_en", int'(n_en), 0);
    check_eq("rst_w", int'(n_W), 0);
    check_eq("rst_x", int'(n_X), 0);
    check_eq("rst_valid", int'(res_valid), 0);
    check_eq("rst_data", int'(res_data), 0);
    check_eq("rst_nrst", int'(n_rst), 1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_nrst", int'(n_rst), 0);

    // Zero all entries so the model and buffers agree before partial loads.
    for (int i = 0; i < DEPTH; i++) load(i, 0, 0);

    load(0, 1, 4); load(1, 2, 5); load(2, 3, 6);
    run("t1", 3, 0);

    load(0, -3, 5);
    run("t2", 1, 0);

    load(0, 1, 4);
    run("t3", 3, 5);

    for (int i = 0; i < DEPTH; i++)
      load(i, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 6)) - 3);
    run("t4_len0", 0, 0);
    run("t4_len20", 20, 0);

    load(0, 1, 4); load(1, 2, 5); load(2, 3, 6);
    @(negedge clk);
    start = 1'b1; len = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("t5_pre_en", int'(n_en), 1);
    rst = 1'b1;
    #1;
    check_eq("t5_nrst", int'(n_rst), 1);
    @(negedge clk);
    rst = 1'b0;
    check_eq("t5_busy", int'(busy), 0);
    check_eq("t5_en", int'(n_en), 0);
    check_eq("t5_valid", int'(res_valid), 0);
    run("t5_rerun", 3, 0);

    load(0, 2, 4); load(1, 0, 7); load(2, 3, 0);
    run("t6", 3, 0);

    for (int r = 0; r < 10; r++) begin
      int l;
      l = int'($urandom_range(0, 20));
      for (int i = 0; i < ((l > DEPTH) ? DEPTH : l); i++)
        load(i, int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8);
      run("rnd", l, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
